sc_pwm_gen: RTL and testbench
=============================

SC_PWM_GEN -- requirements
Module: sc_pwm_gen

Interface
REQ-001 SHALL have parameter PWMGEN_DATAWIDTH, default 16, width W of the period and duty buses.
REQ-002 SHALL have parameter PWMGEN_DEADTIME, default 8, number of clock cycles for the both-legs-low interval.
REQ-003 SHALL have port SC_PWMGEN_CLOCK_50  in  1  the single clock; all logic on its rising edge.
REQ-004 SHALL have port SC_PWMGEN_RESET_InHigh  in  1  reset, synchronous, active-high.
REQ-005 SHALL have port SC_PWMGEN_enable_InLow  in  1  run enable, active-low.
REQ-006 SHALL have port SC_PWMGEN_period_InBUS  in  W  PWM period in clock cycles, unsigned.
REQ-007 SHALL have port SC_PWMGEN_duty_InBUS  in  W  signed two's-complement duty (sign = direction, magnitude = high cycles); driven by the upstream duty register's output bus.
REQ-008 SHALL have port SC_PWMGEN_pwmA_Out  out  1  H-bridge leg A (forward).
REQ-009 SHALL have port SC_PWMGEN_pwmB_Out  out  1  H-bridge leg B (reverse).
REQ-010 SHALL have port SC_PWMGEN_dir_Out  out  1  current direction (0 forward, 1 reverse).
REQ-011 SHALL have port SC_PWMGEN_periodEnd_Out  out  1  one-cycle pulse on the last cycle of each period.

Function
REQ-012 SHALL implement FSM states IDLE, DEADTIME, RUN; all outputs registered.
REQ-013 IDLE: counters 0, pwmA=pwmB=0, periodEnd=0; on enable_InLow=0, latch period/duty into shadow registers, set dir from duty sign, go DEADTIME.
REQ-014 DEADTIME: pwmA=pwmB=0 for exactly PWMGEN_DEADTIME cycles, then go RUN with period counter cnt=0.
REQ-015 RUN: cnt increments each cycle from 0 to Pshadow-1, then wraps to 0.
REQ-016 Pshadow SHALL be the latched period clamped to a minimum of 2 (period 0 or 1 runs as 2).
REQ-017 Magnitude M = |duty| computed in W unsigned bits (-2^(W-1) gives 2^(W-1)), then saturated to Pshadow.
REQ-018 Active leg (A if dir=0, B if dir=1) SHALL be 1 when cnt<M, else 0; the inactive leg SHALL be 0; legs never both 1.
REQ-019 M=0: active leg constantly 0; M>=Pshadow: active leg constantly 1.
REQ-020 periodEnd SHALL pulse for one cycle when cnt=Pshadow-1 in RUN only.
REQ-021 Shadow period/duty SHALL reload only at wrap (cnt=Pshadow-1) and on leaving IDLE; bus changes mid-period SHALL NOT affect the current period.
REQ-022 At wrap, if the new duty is nonzero and its sign differs from dir: update dir, go DEADTIME; otherwise continue RUN at cnt=0.
REQ-023 Duty=0 SHALL NOT change dir.
REQ-024 Output registers SHALL lag cnt by one cycle; pwm/periodEnd for cnt value k appear in the cycle after cnt=k.
REQ-025 enable_InLow=1 in any state SHALL force IDLE at the next edge, legs 0 in that same next cycle, including mid-DEADTIME.
REQ-026 Reset and enable deassert simultaneously: reset wins; result identical to reset.

Reset
REQ-027 On RESET_InHigh=1 at a clock edge: state IDLE, cnt=0, deadtime counter=0, shadows=0, dir=0, pwmA=pwmB=periodEnd=0.
REQ-028 Reset SHALL take effect only at a clock edge; no asynchronous path.
REQ-029 Reset mid-RUN or mid-DEADTIME SHALL abort the cycle; after release with enable low, a full PWMGEN_DEADTIME interval precedes RUN.

Verification (W=16, DEADTIME=8)
REQ-030 period=10, duty=3, enable low after reset -> 8 cycles both low, then pwmA high 3 of every 10 cycles, pwmB=0, periodEnd every 10 cycles, dir=0.
REQ-031 period=10, duty=3, duty changed to 7 at cnt=4 -> current period stays 3 high; next period 7 high.
REQ-032 duty +5 to -5 mid-period -> at wrap both legs low 8 cycles, dir=1, then pwmB high 5 of 10, pwmA=0.
REQ-033 period=10: duty=20 -> pwmA constant 1; duty=0 -> both 0, dir unchanged; duty=-32768 -> pwmB constant 1 after deadtime.
REQ-034 period=1, duty=1 -> runs as period 2, pwmA 1 cycle high per 2, periodEnd every 2 cycles.
REQ-035 Reset asserted one cycle during RUN, enable held low -> next cycle all outputs 0; after release 8 low cycles then RUN restarts at cnt=0; enable_InLow=1 mid-DEADTIME -> IDLE next cycle, outputs 0.

Source files
------------

// File: rtl/sc_pwm_gen.sv
// Sign-magnitude PWM generator for an H-bridge: one leg is driven per direction,
// with a both-legs-low dead interval on start-up and on every direction reversal.
module sc_pwm_gen #(
    parameter int PWMGEN_DATAWIDTH = 16,
    parameter int PWMGEN_DEADTIME  = 8
) (
    input  logic                        SC_PWMGEN_CLOCK_50,
    input  logic                        SC_PWMGEN_RESET_InHigh,
    input  logic                        SC_PWMGEN_enable_InLow,
    input  logic [PWMGEN_DATAWIDTH-1:0] SC_PWMGEN_period_InBUS,
    input  logic [PWMGEN_DATAWIDTH-1:0] SC_PWMGEN_duty_InBUS,
    output logic                        SC_PWMGEN_pwmA_Out,
    output logic                        SC_PWMGEN_pwmB_Out,
    output logic                        SC_PWMGEN_dir_Out,
    output logic                        SC_PWMGEN_periodEnd_Out
);

    localparam int W   = PWMGEN_DATAWIDTH;
    localparam int DTW = (PWMGEN_DEADTIME > 1) ? $clog2(PWMGEN_DEADTIME) : 1;
    localparam logic [DTW-1:0] DT_LAST = DTW'(PWMGEN_DEADTIME - 1);

    typedef enum logic [1:0] {IDLE, DEADTIME, RUN} state_t;

    state_t         state_q;
    logic [W-1:0]   periodSh_q;
    logic [W-1:0]   dutySh_q;
    logic [W-1:0]   cnt_q;
    logic [DTW-1:0] dtCnt_q;
    logic           dir_q;
    logic           pwmA_q;
    logic           pwmB_q;
    logic           periodEnd_q;

    logic [W-1:0]   periodEff;
    logic [W-1:0]   dutyMag;
    logic [W-1:0]   magSat;
    logic           activeLeg;
    logic           lastCycle;
    logic           newSign;
    logic           flipDir;

    // A period below 2 would leave no room for both a high and a low phase.
    assign periodEff = (periodSh_q < W'(2)) ? W'(2) : periodSh_q;
    // Two's-complement negate in W bits, so the most negative duty maps to 2^(W-1).
    assign dutyMag   = dutySh_q[W-1] ? (~dutySh_q + W'(1)) : dutySh_q;
    assign magSat    = (dutyMag > periodEff) ? periodEff : dutyMag;
    assign activeLeg = (cnt_q < magSat);
    assign lastCycle = (cnt_q == periodEff - W'(1));
    assign newSign   = SC_PWMGEN_duty_InBUS[W-1];
    assign flipDir   = (SC_PWMGEN_duty_InBUS != '0) && (newSign != dir_q);

    always_ff @(posedge SC_PWMGEN_CLOCK_50) begin
        if (SC_PWMGEN_RESET_InHigh) begin
            state_q     <= IDLE;
            periodSh_q  <= '0;
            dutySh_q    <= '0;
            cnt_q       <= '0;
            dtCnt_q     <= '0;
            dir_q       <= 1'b0;
            pwmA_q      <= 1'b0;
            pwmB_q      <= 1'b0;
            periodEnd_q <= 1'b0;
        end else if (SC_PWMGEN_enable_InLow) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            dtCnt_q     <= '0;
            pwmA_q      <= 1'b0;
            pwmB_q      <= 1'b0;
            periodEnd_q <= 1'b0;
        end else begin
            pwmA_q      <= 1'b0;
            pwmB_q      <= 1'b0;
            periodEnd_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    periodSh_q <= SC_PWMGEN_period_InBUS;
                    dutySh_q   <= SC_PWMGEN_duty_InBUS;
                    dir_q      <= newSign;
                    cnt_q      <= '0;
                    dtCnt_q    <= '0;
                    state_q    <= DEADTIME;
                end
                DEADTIME: begin
                    if (dtCnt_q == DT_LAST) begin
                        cnt_q   <= '0;
                        state_q <= RUN;
                    end else begin
                        dtCnt_q <= dtCnt_q + DTW'(1);
                    end
                end
                RUN: begin
                    // Outputs reflect the count of the current cycle, hence lag cnt by one.
                    pwmA_q      <= activeLeg & ~dir_q;
                    pwmB_q      <= activeLeg & dir_q;
                    periodEnd_q <= lastCycle;
                    if (lastCycle) begin
                        periodSh_q <= SC_PWMGEN_period_InBUS;
                        dutySh_q   <= SC_PWMGEN_duty_InBUS;
                        cnt_q      <= '0;
                        if (flipDir) begin
                            dir_q   <= newSign;
                            dtCnt_q <= '0;
                            state_q <= DEADTIME;
                        end
                    end else begin
                        cnt_q <= cnt_q + W'(1);
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign SC_PWMGEN_pwmA_Out      = pwmA_q;
    assign SC_PWMGEN_pwmB_Out      = pwmB_q;
    assign SC_PWMGEN_dir_Out       = dir_q;
    assign SC_PWMGEN_periodEnd_Out = periodEnd_q;

endmodule

// File: tb/tb_sc_pwm_gen.sv
// Bench for sc_pwm_gen: directed scenarios plus random traffic, all checked against
// a cycle-level behavioural model of the generator kept in this file.
module tb_sc_pwm_gen;

    localparam int W  = 16;
    localparam int DT = 8;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         enN = 1'b0;
    logic [W-1:0] period = '0;
    logic [W-1:0] duty = '0;
    logic         pwmA, pwmB, dirO, pEnd;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    // Model: idle flag, remaining dead cycles, position in period, latched shadows.
    bit mIdle = 1'b1;
    int mDead = 0;
    int mPos  = 0;
    int mP    = 0;
    int mDuty = 0;
    bit mDir  = 1'b0;
    bit eA = 1'b0, eB = 1'b0, eE = 1'b0;

    always #5 clk = ~clk;

    sc_pwm_gen #(.PWMGEN_DATAWIDTH(W), .PWMGEN_DEADTIME(DT)) dut (
        .SC_PWMGEN_CLOCK_50      (clk),
        .SC_PWMGEN_RESET_InHigh  (rst),
        .SC_PWMGEN_enable_InLow  (enN),
        .SC_PWMGEN_period_InBUS  (period),
        .SC_PWMGEN_duty_InBUS    (duty),
        .SC_PWMGEN_pwmA_Out      (pwmA),
        .SC_PWMGEN_pwmB_Out      (pwmB),
        .SC_PWMGEN_dir_Out       (dirO),
        .SC_PWMGEN_periodEnd_Out (pEnd)
    );

    task automatic modelEdge();
        int  pe, mag;
        bit  running;
        if (rst) begin
            mIdle = 1'b1; mDead = 0; mPos = 0; mP = 0; mDuty = 0; mDir = 1'b0;
            eA = 1'b0; eB = 1'b0; eE = 1'b0;
        end else if (enN) begin
            mIdle = 1'b1; mDead = 0; mPos = 0;
            eA = 1'b0; eB = 1'b0; eE = 1'b0;
        end else begin
            running = !mIdle && (mDead == 0);
            pe  = (mP < 2) ? 2 : mP;
            mag = (mDuty < 0) ? -mDuty : mDuty;
            eA  = running && (mPos < mag) && !mDir;
            eB  = running && (mPos < mag) && mDir;
            eE  = running && (mPos == pe - 1);
            if (mIdle) begin
                mP = int'(period); mDuty = int'($signed(duty));
                mDir = (mDuty < 0); mIdle = 1'b0; mDead = DT; mPos = 0;
            end else if (mDead > 0) begin
                mDead--; mPos = 0;
            end else if (mPos == pe - 1) begin
                mP = int'(period); mDuty = int'($signed(duty)); mPos = 0;
                if (mDuty != 0 && ((mDuty < 0) != mDir)) begin
                    mDir = (mDuty < 0); mDead = DT;
                end
            end else begin
                mPos++;
            end
        end
    endtask

    task automatic tick();
        @(posedge clk);
        modelEdge();
        cyc++;
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1; enN = 1'b0; period = 16'd10; duty = 16'd3;
        for (int i = 0; i < 3; i++) begin
            tick();
            total++;
            if ({pwmA, pwmB, dirO, pEnd} !== 4'b0000) begin
                bad++;
                $display("[TB] FAIL reset cyc=%0d got=%b want=0000", cyc, {pwmA, pwmB, dirO, pEnd});
            end
        end
        // Reset and enable released together: reset must still win.
        enN = 1'b1;
        tick();
        total++;
        if ({pwmA, pwmB, dirO, pEnd} !== 4'b0000) begin
            bad++;
            $display("[TB] FAIL reset_vs_enable cyc=%0d got=%b want=0000", cyc, {pwmA, pwmB, dirO, pEnd});
        end
        enN = 1'b0;
    endtask

    task automatic test_basic();
        int highs = 0, ends = 0, earlyHigh = 0;
        period = 16'd10; duty = 16'd3; enN = 1'b0;
        for (int i = 0; i < 50; i++) begin
            rst = (i == 0);
            tick();
            total++;
            if ({pwmA, pwmB, dirO, pEnd} !== {eA, eB, mDir, eE}) begin
                bad++;
                $display("[TB] FAIL basic cyc=%0d got=%b want=%b", cyc, {pwmA, pwmB, dirO, pEnd}, {eA, eB, mDir, eE});
            end
            if (i >= 1 && i <= 9 && (pwmA || pwmB)) earlyHigh++;
            if (i >= 30 && i <= 39) begin highs += int'(pwmA); ends += int'(pEnd); end
        end
        total++;
        if (earlyHigh !== 0) begin bad++; $display("[TB] FAIL basic_deadtime got=%0d want=0", earlyHigh); end
        total++;
        if (highs !== 3) begin bad++; $display("[TB] FAIL basic_highs got=%0d want=3", highs); end
        total++;
        if (ends !== 1) begin bad++; $display("[TB] FAIL basic_periodend got=%0d want=1", ends); end
    endtask

    task automatic test_shadow();
        int h1 = 0, h2 = 0;
        period = 16'd10; duty = 16'd3; enN = 1'b0;
        for (int i = 0; i < 32; i++) begin
            rst = (i == 0);
            tick();
            total++;
            if ({pwmA, pwmB, dirO, pEnd} !== {eA, eB, mDir, eE}) begin
                bad++;
                $display("[TB] FAIL shadow cyc=%0d got=%b want=%b", cyc, {pwmA, pwmB, dirO, pEnd}, {eA, eB, mDir, eE});
            end
            if (i >= 10 && i <= 19) h1 += int'(pwmA);
            if (i >= 20 && i <= 29) h2 += int'(pwmA);
            if (i == 13) duty = 16'd7;
        end
        total++;
        if (h1 !== 3) begin bad++; $display("[TB] FAIL shadow_current got=%0d want=3", h1); end
        total++;
        if (h2 !== 7) begin bad++; $display("[TB] FAIL shadow_next got=%0d want=7", h2); end
    endtask

    task automatic test_direction();
        int hb = 0, ha = 0, lowDead = 0;
        period = 16'd10; duty = 16'd5; enN = 1'b0;
        for (int i = 0; i < 40; i++) begin
            rst = (i == 0);
            tick();
            total++;
            if ({pwmA, pwmB, dirO, pEnd} !== {eA, eB, mDir, eE}) begin
                bad++;
                $display("[TB] FAIL direction cyc=%0d got=%b want=%b", cyc, {pwmA, pwmB, dirO, pEnd}, {eA, eB, mDir, eE});
            end
            if (i >= 19 && i <= 26 && (pwmA || pwmB)) lowDead++;
            if (i >= 27 && i <= 36) begin hb += int'(pwmB); ha += int'(pwmA); end
            if (i == 13) duty = 16'hFFFB;
        end
        total++;
        if (lowDead !== 0) begin bad++; $display("[TB] FAIL direction_dead got=%0d want=0", lowDead); end
        total++;
        if (hb !== 5 || ha !== 0) begin bad++; $display("[TB] FAIL direction_legs gotB=%0d gotA=%0d want 5/0", hb, ha); end
        total++;
        if (dirO !== 1'b1) begin bad++; $display("[TB] FAIL direction_dir got=%b want=1", dirO); end
    endtask

    task automatic test_saturate();
        int onesA = 0, onesB = 0;
        period = 16'd10; duty = 16'd20; enN = 1'b0;
        for (int i = 0; i < 90; i++) begin
            rst = (i == 0);
            tick();
            total++;
            if ({pwmA, pwmB, dirO, pEnd} !== {eA, eB, mDir, eE}) begin
                bad++;
                $display("[TB] FAIL saturate cyc=%0d got=%b want=%b", cyc, {pwmA, pwmB, dirO, pEnd}, {eA, eB, mDir, eE});
            end
            if (i >= 10 && i <= 29) onesA += int'(pwmA);
            if (i >= 78 && i <= 87) onesB += int'(pwmB);
            if (i == 30) duty = 16'd0;
            if (i == 50) duty = 16'h8000;
        end
        total++;
        if (onesA !== 20) begin bad++; $display("[TB] FAIL saturate_full got=%0d want=20", onesA); end
        total++;
        if (onesB !== 10) begin bad++; $display("[TB] FAIL saturate_negmax got=%0d want=10", onesB); end
    endtask

    task automatic test_min_period();
        int highs = 0, ends = 0;
        period = 16'd1; duty = 16'd1; enN = 1'b0;
        for (int i = 0; i < 30; i++) begin
            rst = (i == 0);
            tick();
            total++;
            if ({pwmA, pwmB, dirO, pEnd} !== {eA, eB, mDir, eE}) begin
                bad++;
                $display("[TB] FAIL min_period cyc=%0d got=%b want=%b", cyc, {pwmA, pwmB, dirO, pEnd}, {eA, eB, mDir, eE});
            end
            if (i >= 10 && i <= 19) begin highs += int'(pwmA); ends += int'(pEnd); end
        end
        total++;
        if (highs !== 5 || ends !== 5) begin
            bad++;
            $display("[TB] FAIL min_period_counts highs=%0d ends=%0d want 5/5", highs, ends);
        end
    endtask

    task automatic test_abort();
        period = 16'd10; duty = 16'd4; enN = 1'b0;
        for (int i = 0; i < 60; i++) begin
            rst = (i == 0) || (i == 25);
            enN = (i == 30);
            tick();
            total++;
            if ({pwmA, pwmB, dirO, pEnd} !== {eA, eB, mDir, eE}) begin
                bad++;
                $display("[TB] FAIL abort cyc=%0d got=%b want=%b", cyc, {pwmA, pwmB, dirO, pEnd}, {eA, eB, mDir, eE});
            end
            if (i == 25 || i == 30) begin
                total++;
                if ({pwmA, pwmB, pEnd} !== 3'b000) begin
                    bad++;
                    $display("[TB] FAIL abort_clear cyc=%0d got=%b want=000", cyc, {pwmA, pwmB, pEnd});
                end
            end
        end
    endtask

    task automatic test_random();
        int d;
        rst = 1'b1; enN = 1'b0; period = 16'd6; duty = 16'd2;
        for (int i = 0; i < 800; i++) begin
            tick();
            total++;
            if ({pwmA, pwmB, dirO, pEnd} !== {eA, eB, mDir, eE}) begin
                bad++;
                $display("[TB] FAIL random cyc=%0d got=%b want=%b", cyc, {pwmA, pwmB, dirO, pEnd}, {eA, eB, mDir, eE});
            end
            rst = ($urandom_range(0, 249) == 0);
            enN = ($urandom_range(0, 59) == 0);
            if ($urandom_range(0, 19) == 0) period = 16'($urandom_range(0, 12));
            if ($urandom_range(0, 9) == 0) begin
                d = int'($urandom_range(0, 30)) - 15;
                if ($urandom_range(0, 15) == 0) d = -32768;
                duty = 16'(d);
            end
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_shadow();
        test_direction();
        test_saturate();
        test_min_period();
        test_abort();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
